rectify: RTL and testbench

Activation stage placed directly downstream of `associate`. It accepts the neuron's signed Q8.8 sum on a strobe/ready stream and produces a clamped unsigned activation suitable as an `associate` argument byte. On the backward pass it accepts an error and returns it gated by the activation derivative as feedback to the upstream `associate`. Each forward/backward exchange is sequenced by a small handshake state machine; `en` selects training (backward pass required) or inference (forward only).

---
 rtl/machina_pkg.sv | 18 +
 rtl/rectify_saturate.sv | 33 +++
 rtl/rectify.sv | 104 ++++++++++
 tb/tb_rectify.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/machina_pkg.sv
// Shared types for the machina neuron pipeline: Q8.8 fixed-point values,
// unsigned activation bytes and the rectify handshake state encoding.
package machina_pkg;

    localparam int FIX_W  = 16;
    localparam int UNIT_W = 8;

    typedef logic signed [FIX_W-1:0] fixed_t;
    typedef logic [UNIT_W-1:0]       unit_t;

    typedef enum logic [1:0] {
        ARG = 2'd0,
        RES = 2'd1,
        ERR = 2'd2,
        FBK = 2'd3
    } rectify_state_t;

endpackage

// File: rtl/rectify_saturate.sv
// saturate: clamps a signed W-bit value into the unsigned range [0, 2**R-1].
// Ports: val (signed in), res (clamped out), in_range (1 when no clamping).
module saturate
    import machina_pkg::*;
#(
    parameter int W = FIX_W,
    parameter int R = UNIT_W
) (
    input  logic [W-1:0] val,
    output logic [R-1:0] res,
    output logic         in_range
);

    // Ceiling 2**R-1 zero-extended to W bits; compared on the full width.
    localparam logic [W-1:0] CEIL = {{(W-R){1'b0}}, {R{1'b1}}};

    logic neg;
    logic over;

    assign neg      = val[W-1];
    assign over     = !neg && (val > CEIL);
    assign in_range = !neg && !over;

    always_comb begin
        res = val[R-1:0];
        if (neg) begin
            res = '0;
        end else if (over) begin
            res = '1;
        end
    end

endmodule

// File: rtl/rectify.sv
// rectify: clamped activation stage with derivative-gated backward pass.
// Ports: clk, rst (sync, active high), en (training), arg/res/err/fbk
// strobe-ready streams. Optional macro RECTIFY_LEAKY_EN scales negative-
// region feedback by 2**-LEAK instead of zeroing it.
module rectify
    import machina_pkg::*;
#(
    parameter int W    = FIX_W,
    parameter int R    = UNIT_W,
    parameter int LEAK = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         arg_stb,
    output logic         arg_rdy,
    input  logic [W-1:0] arg_dat,
    output logic         res_stb,
    input  logic         res_rdy,
    output logic [R-1:0] res_dat,
    input  logic         err_stb,
    output logic         err_rdy,
    input  logic [W-1:0] err_dat,
    output logic         fbk_stb,
    input  logic         fbk_rdy,
    output logic [W-1:0] fbk_dat
);

    if (LEAK < 0 || LEAK >= W) begin : g_bad_leak
        $error("rectify: LEAK must lie in [0, W-1]");
    end

    rectify_state_t state;
    logic [W-1:0]   x;
    logic           in_range;
    logic [W-1:0]   gated;

    // The clamp of the held argument is the result; the same in-range
    // flag is the activation derivative used to gate the error.
    saturate #(
        .W(W),
        .R(R)
    ) u_sat (
        .val     (x),
        .res     (res_dat),
        .in_range(in_range)
    );

    always_comb begin
        gated = '0;
        if (in_range) begin
            gated = err_dat;
        end
`ifdef RECTIFY_LEAKY_EN
        else if (x[W-1]) begin
            gated = $signed(err_dat) >>> LEAK;
        end
`endif
    end

    assign arg_rdy = (state == ARG);
    assign res_stb = (state == RES);
    assign err_rdy = (state == ERR);
    assign fbk_stb = (state == FBK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARG;
            x       <= '0;
            fbk_dat <= '0;
        end else begin
            unique case (state)
                ARG: begin
                    if (arg_stb) begin
                        x     <= arg_dat;
                        state <= RES;
                    end
                end
                RES: begin
                    if (res_rdy) begin
                        state <= en ? ERR : ARG;
                    end
                end
                ERR: begin
                    // A completed handshake wins over a falling en so the
                    // upstream never loses an error it saw accepted.
                    if (err_stb) begin
                        fbk_dat <= gated;
                        state   <= FBK;
                    end else if (!en) begin
                        state <= ARG;
                    end
                end
                FBK: begin
                    if (fbk_rdy) begin
                        state <= ARG;
                    end
                end
                default: state <= ARG;
            endcase
        end
    end

endmodule

// File: tb/tb_rectify.sv
// Self-checking bench for rectify: directed vectors from the test plan,
// then randomized exchanges against a behavioural reference model.
module tb_rectify;

    localparam int W    = 16;
    localparam int R    = 8;
    localparam int LEAK = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         arg_stb = 1'b0;
    logic         arg_rdy;
    logic [W-1:0] arg_dat = '0;
    logic         res_stb;
    logic         res_rdy = 1'b0;
    logic [R-1:0] res_dat;
    logic         err_stb = 1'b0;
    logic         err_rdy;
    logic [W-1:0] err_dat = '0;
    logic         fbk_stb;
    logic         fbk_rdy = 1'b0;
    logic [W-1:0] fbk_dat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rectify #(.W(W), .R(R), .LEAK(LEAK)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .arg_stb(arg_stb),
        .arg_rdy(arg_rdy),
        .arg_dat(arg_dat),
        .res_stb(res_stb),
        .res_rdy(res_rdy),
        .res_dat(res_dat),
        .err_stb(err_stb),
        .err_rdy(err_rdy),
        .err_dat(err_dat),
        .fbk_stb(fbk_stb),
        .fbk_rdy(fbk_rdy),
        .fbk_dat(fbk_dat)
    );

    function automatic int ref_res(input logic [W-1:0] a);
        int v;
        v = int'($signed(a));
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int ref_fbk(input logic [W-1:0] a,
                                   input logic [W-1:0] e);
        int v;
        int ev;
        v  = int'($signed(a));
        ev = int'($signed(e));
        if (v >= 0 && v <= 255) return ev & 16'hffff;
`ifdef RECTIFY_LEAKY_EN
        if (v < 0) return (ev >>> LEAK) & 16'hffff;
`endif
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full exchange; res_wait/fbk_wait cycles of backpressure.
    task automatic exchange(input logic [W-1:0] a, input logic [W-1:0] e,
                            input logic train, input int res_wait,
                            input int fbk_wait, input string tag);
        int er;
        int ef;
        er = ref_res(a);
        ef = ref_fbk(a, e);
        en = train;
        check({tag, ".arg_rdy"}, int'(arg_rdy), 1);
        arg_stb = 1'b1;
        arg_dat = a;
        tick();
        arg_stb = 1'b0;
        arg_dat = $urandom;
        for (int i = 0; i < res_wait; i++) begin
            check({tag, ".res_hold_stb"}, int'(res_stb), 1);
            check({tag, ".res_hold_dat"}, int'(res_dat), er);
            check({tag, ".res_hold_err_rdy"}, int'(err_rdy), 0);
            tick();
        end
        check({tag, ".res_stb"}, int'(res_stb), 1);
        check({tag, ".res_dat"}, int'(res_dat), er);
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        if (!train) begin
            check({tag, ".back_arg"}, int'(arg_rdy), 1);
            return;
        end
        check({tag, ".err_rdy"}, int'(err_rdy), 1);
        err_stb = 1'b1;
        err_dat = e;
        tick();
        err_stb = 1'b0;
        err_dat = $urandom;
        for (int i = 0; i < fbk_wait; i++) begin
            check({tag, ".fbk_hold_stb"}, int'(fbk_stb), 1);
            check({tag, ".fbk_hold_dat"}, int'(fbk_dat), ef);
            tick();
        end
        check({tag, ".fbk_stb"}, int'(fbk_stb), 1);
        check({tag, ".fbk_dat"}, int'(fbk_dat), ef);
        fbk_rdy = 1'b1;
        tick();
        fbk_rdy = 1'b0;
        check({tag, ".fbk_done"}, int'(arg_rdy), 1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] e;
        tick();
        tick();
        rst = 1'b0;
        check("rst.arg_rdy", int'(arg_rdy), 1);
        check("rst.res_stb", int'(res_stb), 0);
        check("rst.err_rdy", int'(err_rdy), 0);
        check("rst.fbk_stb", int'(fbk_stb), 0);
        check("rst.res_dat", int'(res_dat), 0);
        check("rst.fbk_dat", int'(fbk_dat), 0);

        exchange(16'h0000, 16'h0, 1'b0, 0, 0, "zero");
        exchange(16'hff80, 16'h0, 1'b0, 0, 0, "clamp_neg");
        exchange(16'h0080, 16'h0, 1'b0, 0, 0, "clamp_mid");
        exchange(16'h0100, 16'h0, 1'b0, 0, 0, "clamp_256");
        exchange(16'h7fff, 16'h0, 1'b0, 0, 0, "clamp_max");
        exchange(16'h00ff, 16'h0, 1'b0, 0, 0, "clamp_255");
        exchange(16'h8000, 16'h0, 1'b0, 0, 0, "clamp_min");

        exchange(16'h0040, 16'h0020, 1'b1, 0, 0, "train_in");
        exchange(16'h0200, 16'h0020, 1'b1, 0, 0, "train_sat");
        exchange(16'hff00, 16'h0040, 1'b1, 0, 0, "train_neg");
        exchange(16'hfff0, 16'hffc1, 1'b1, 0, 0, "train_neg2");
        exchange(16'h00ff, 16'h8001, 1'b1, 0, 0, "train_edge");

        exchange(16'h0033, 16'h1234, 1'b1, 5, 5, "bp");

        en = 1'b1;
        arg_stb = 1'b1;
        arg_dat = 16'h0010;
        tick();
        arg_stb = 1'b0;
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        check("abort.in_err", int'(err_rdy), 1);
        en = 1'b0;
        tick();
        check("abort.err_rdy", int'(err_rdy), 0);
        check("abort.arg_rdy", int'(arg_rdy), 1);
        check("abort.res_dat", int'(res_dat), 16);

        en = 1'b1;
        arg_stb = 1'b1;
        arg_dat = 16'h0020;
        tick();
        arg_stb = 1'b0;
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        err_stb = 1'b1;
        err_dat = 16'h0007;
        tick();
        err_stb = 1'b0;
        check("rstfbk.fbk_stb", int'(fbk_stb), 1);
        check("rstfbk.fbk_dat", int'(fbk_dat), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstfbk.fbk_gone", int'(fbk_stb), 0);
        check("rstfbk.arg_rdy", int'(arg_rdy), 1);
        check("rstfbk.fbk_zero", int'(fbk_dat), 0);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: a = W'($urandom_range(0, 255));
                1: a = W'(-int'($urandom_range(1, 300)));
                2: a = W'($urandom_range(250, 270));
                default: a = W'($urandom);
            endcase
            e = W'($urandom);
            exchange(a, e, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
